// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side issues operations; the slave side is the subtractor.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output start, A, B, Bi,
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B, Bi,
    output busy, done, D, Bout
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bi computed LSB first, one bit per clock,
// through a single full-subtractor cell with a registered borrow.
// D/Bout are only written on the edge that completes an operation, so they
// never show partial results and hold until the next operation finishes.
module bit_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic br);
    logic diff;
    logic bor;
    diff = a ^ b ^ br;
    bor  = (~a & b) | (~(a ^ b) & br);
    return {bor, diff};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Upper WIDTH-1 bits of the result shift register; the bit that would fall
  // out of the bottom is never needed, so it is not stored.
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] shifted_s;
  logic             last_s;
  logic             busy_s;
  logic             done_s;

  assign cell_s    = fs_cell(a_sr_q[0], b_sr_q[0], br_q);
  assign shifted_s = {cell_s[0], res_q};
  assign last_s    = (cnt_q == CNT_LAST);

  // State register plus all datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand load on accept, one serial bit per RUN cycle, result
  // committed only on the final bit.
  always_comb begin
    a_sr_d = a_sr_q;
    b_sr_d = b_sr_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    d_d    = d_q;
    bout_d = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d = bus.A;
          b_sr_d = bus.B;
          br_d   = bus.Bi;
          cnt_d  = '0;
        end else begin
          a_sr_d = a_sr_q;
          b_sr_d = b_sr_q;
        end
      end
      ST_RUN: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d  = shifted_s[WIDTH-1:1];
        br_d   = cell_s[1];
        cnt_d  = cnt_q + CW'(1);
        if (last_s) begin
          d_d    = shifted_s;
          bout_d = cell_s[1];
        end else begin
          d_d    = d_q;
          bout_d = bout_q;
        end
      end
      ST_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  assign bus.busy = busy_s;
  assign bus.done = done_s;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH=4).
// Stimulus pushes expected {Bout,D} into a queue; a monitor pops and compares
// on every done pulse and checks that D/Bout hold steady while busy.
module tb_bit_serial_subtractor;
  localparam int W = 4;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #(PERIOD/2) clk = ~clk;

  bit_serial_subtractor_if #(.WIDTH(W)) bus();

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         push_cnt = 0;
  int         done_cnt = 0;
  logic [W:0] exp_q[$];
  logic [W:0] hold = '0;
  logic [W:0] mon_e;
  time        done_times[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare results on done, check output stability while running.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_times.push_back($time);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {bus.Bout, bus.D}, mon_e);
          hold = mon_e;
        end
      end else if (bus.busy === 1'b1) begin
        check("hold_during_run", {bus.Bout, bus.D}, hold);
      end
    end
  end

  // Drive point: 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && bus.busy !== 1'b0; i++) tick();
    check("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W:0] e, input bit push);
    wait_idle();
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bi    = bi;
    if (push) begin
      exp_q.push_back(e);
      push_cnt++;
    end
    tick();
    bus.start = 1'b0;
  endtask

  // Directed vectors: A, B, Bi, expected {Bout,D}
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W:0]   e;
  } vec_t;

  vec_t dir_vecs[6] = '{
    '{4'd3,  4'd5,  1'b0, {1'b1, 4'd14}},
    '{4'd0,  4'd0,  1'b1, {1'b1, 4'd15}},
    '{4'd15, 4'd0,  1'b0, {1'b0, 4'd15}},
    '{4'd0,  4'd15, 1'b1, {1'b1, 4'd0}},
    '{4'd15, 4'd15, 1'b1, {1'b1, 4'd15}},
    '{4'd8,  4'd8,  1'b0, {1'b0, 4'd0}}
  };

  initial begin
    #(PERIOD * 2000000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    logic [W:0] e;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bi    = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_D",    {28'd0, bus.D},    32'd0);
    check("reset_Bout", {31'd0, bus.Bout}, 32'd0);
    rst_n = 1'b1;
    hold  = '0;
    tick();

    // 9 - 5: timing of busy/done relative to the accepting edge (k=0)
    issue(4'd9, 4'd5, 1'b0, {1'b0, 4'd4}, 1'b1);
    busy_cycles = 0;
    for (int k = 0; k <= W + 2; k++) begin
      check("timing_busy", {31'd0, bus.busy}, (k <= W) ? 32'd1 : 32'd0);
      check("timing_done", {31'd0, bus.done}, (k == W) ? 32'd1 : 32'd0);
      if (bus.busy === 1'b1) busy_cycles++;
      tick();
    end
    check("busy_length", busy_cycles, W + 1);

    // Hand-computed directed vectors
    for (int i = 0; i < 6; i++) begin
      issue(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].bi, dir_vecs[i].e, 1'b1);
    end

    // start re-pulsed and operands changed during RUN and DONE are ignored
    issue(4'd6, 4'd3, 1'b0, {1'b0, 4'd3}, 1'b1);
    for (int k = 1; k <= W + 1; k++) begin
      bus.start = 1'b1;
      bus.A     = 4'd15;
      bus.B     = 4'd1;
      bus.Bi    = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    wait_idle();

    // Reset two bits into an operation: abort, no done
    issue(4'd9, 4'd5, 1'b0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    hold  = '0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_D",    {28'd0, bus.D},    32'd0);
    check("abort_Bout", {31'd0, bus.Bout}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(4'd7, 4'd2, 1'b0, {1'b0, 4'd5}, 1'b1);

    // Exhaustive sweep against the arithmetic reference
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          e = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
          issue(4'(a), 4'(b), 1'(bi), e, 1'b1);
        end
      end
    end

    // start held high for three back-to-back operations
    wait_idle();
    done_times.delete();
    bus.start = 1'b1;
    bus.A = 4'd10; bus.B = 4'd3; bus.Bi = 1'b1;
    exp_q.push_back({1'b0, 4'd6});  push_cnt++;
    tick();
    bus.A = 4'd4;  bus.B = 4'd9; bus.Bi = 1'b0;
    exp_q.push_back({1'b1, 4'd11}); push_cnt++;
    repeat (W + 2) tick();
    bus.A = 4'd12; bus.B = 4'd12; bus.Bi = 1'b0;
    exp_q.push_back({1'b0, 4'd0});  push_cnt++;
    repeat (W + 2) tick();
    bus.start = 1'b0;
    wait_idle();
    tick();
    check("cont_done_count", done_times.size(), 32'd3);
    if (done_times.size() == 3) begin
      check("cont_spacing_1", 32'(done_times[1] - done_times[0]), (W + 2) * PERIOD);
      check("cont_spacing_2", 32'(done_times[2] - done_times[1]), (W + 2) * PERIOD);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_count", done_cnt, push_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
